// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory between fetch and load/store paths,
//            data-first with a starvation guard so fetch always progresses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_data_out,
  output logic        busy
);

  localparam int LW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q;
  logic            owner_dm_q;
  logic            we_q;
  logic [LW-1:0]   lat_cnt_q;
  logic [SW-1:0]   starve_cnt_q;
  logic [SW-1:0]   starve_cnt_d;
  logic            grant_if_d;
  logic            grant_dm_d;

  // Fetch wins only when alone or once data has used up its streak budget.
  always_comb begin
    grant_if_d = if_req && (!dm_req || (starve_cnt_q == SW'(STARVE_MAX)));
    grant_dm_d = dm_req && !grant_if_d;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == S_IDLE) begin
      if (!if_req || grant_if_d) begin
        starve_cnt_d = '0;
      end else if (grant_dm_d && (starve_cnt_q != SW'(STARVE_MAX))) begin
        starve_cnt_d = starve_cnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_dm_q   <= 1'b0;
      we_q         <= 1'b0;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      if_ack       <= 1'b0;
      if_rdata     <= '0;
      dm_ack       <= 1'b0;
      dm_rdata     <= '0;
      mem_address  <= '0;
      mem_data_in  <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      case (state_q)
        S_IDLE: begin
          // Outputs are registered, so the strobes for ISSUE are set here.
          if (grant_if_d) begin
            state_q     <= S_ISSUE;
            owner_dm_q  <= 1'b0;
            we_q        <= 1'b0;
            mem_address <= if_addr;
            mem_rd      <= 1'b1;
            busy        <= 1'b1;
          end else if (grant_dm_d) begin
            state_q     <= S_ISSUE;
            owner_dm_q  <= 1'b1;
            we_q        <= dm_we;
            mem_address <= dm_addr;
            mem_rd      <= !dm_we;
            mem_wr      <= dm_we;
            busy        <= 1'b1;
            if (dm_we) begin
              mem_data_in <= dm_wdata;
            end
          end
        end
        S_ISSUE: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          if (we_q) begin
            state_q <= S_RESP;
            dm_ack  <= 1'b1;
          end else begin
            state_q   <= S_WAIT;
            lat_cnt_q <= LW'(MEM_LAT);
          end
        end
        S_WAIT: begin
          lat_cnt_q <= lat_cnt_q - LW'(1);
          if (lat_cnt_q == LW'(1)) begin
            state_q <= S_RESP;
            if (owner_dm_q) begin
              dm_rdata <= mem_data_out;
              dm_ack   <= 1'b1;
            end else begin
              if_rdata <= mem_data_out;
              if_ack   <= 1'b1;
            end
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          if_ack  <= 1'b0;
          dm_ack  <= 1'b0;
          busy    <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter (MEM_LAT 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int          nvec = 0;
  int          nerr = 0;

  // DUT with MEM_LAT=1
  logic        if_req, if_ack, dm_req, dm_we, dm_ack, mem_rd, mem_wr, busy;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;

  // DUT with MEM_LAT=3
  logic        if_req3, if_ack3, dm_req3, dm_we3, dm_ack3, mem_rd3, mem_wr3, busy3;
  logic [31:0] if_addr3, if_rdata3, dm_addr3, dm_wdata3, dm_rdata3;
  logic [31:0] mem_address3, mem_data_in3, mem_data_out3;

  logic [31:0] mem [0:1023];
  logic [31:0] pipe3 [0:2];

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_data_out(mem_data_out), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .dm_req(dm_req3), .dm_we(dm_we3), .dm_addr(dm_addr3), .dm_wdata(dm_wdata3),
    .dm_ack(dm_ack3), .dm_rdata(dm_rdata3),
    .mem_address(mem_address3), .mem_data_in(mem_data_in3),
    .mem_rd(mem_rd3), .mem_wr(mem_wr3), .mem_data_out(mem_data_out3), .busy(busy3)
  );

  // Word-addressed memory: registered read, 1-cycle and 3-cycle variants.
  always @(posedge clk) begin
    if (!rst) begin
      mem[512] <= 32'hC200_2818;
      mem[513] <= 32'hC400_2814;
    end else if (mem_wr) begin
      mem[mem_address[11:2]] <= mem_data_in;
    end
    mem_data_out <= mem[mem_address[11:2]];
    pipe3[0]     <= mem[mem_address3[11:2]];
    pipe3[1]     <= pipe3[0];
    pipe3[2]     <= pipe3[1];
  end
  assign mem_data_out3 = pipe3[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [5:0] exp_fetch;
  int         got;

  initial begin
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'd2048;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd12; dm_wdata = 32'h1234_5678;
    if_req3 = 1'b0; if_addr3 = '0; dm_req3 = 1'b0; dm_we3 = 1'b0; dm_addr3 = '0; dm_wdata3 = '0;

    // Reset with both requests high
    tick(); tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_strobes", {30'b0, mem_rd, mem_wr}, 32'd0);
    chk("rst_acks", {30'b0, if_ack, dm_ack}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_busy3", {31'b0, busy3}, 32'd0);
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    tick();
    chk("idle_busy", {31'b0, busy}, 32'd0);

    // Single fetch, MEM_LAT=1
    if_req = 1'b1; if_addr = 32'd2048;
    tick();
    chk("fetch_c1_rd", {30'b0, mem_rd, mem_wr}, 32'd2);
    chk("fetch_c1_addr", mem_address, 32'd2048);
    chk("fetch_c1_busy", {31'b0, busy}, 32'd1);
    tick();
    chk("fetch_c2_rd", {31'b0, mem_rd}, 32'd0);
    chk("fetch_c2_ack", {31'b0, if_ack}, 32'd0);
    tick();
    chk("fetch_c3_acks", {30'b0, if_ack, dm_ack}, 32'd2);
    chk("fetch_c3_rdata", if_rdata, 32'hC200_2818);
    if_req = 1'b0;
    tick();
    chk("fetch_c4_ack", {31'b0, if_ack}, 32'd0);
    chk("fetch_c4_busy", {31'b0, busy}, 32'd0);

    // Store then load
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd12; dm_wdata = 32'hDEAD_BEEF;
    tick();
    chk("st_c1_strobes", {30'b0, mem_rd, mem_wr}, 32'd1);
    chk("st_c1_addr", mem_address, 32'd12);
    chk("st_c1_wdata", mem_data_in, 32'hDEAD_BEEF);
    tick();
    chk("st_c2_acks", {30'b0, if_ack, dm_ack}, 32'd1);
    chk("st_c2_strobes", {30'b0, mem_rd, mem_wr}, 32'd0);
    dm_req = 1'b0;
    tick();
    chk("st_c3_ack", {31'b0, dm_ack}, 32'd0);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd12; dm_wdata = 32'h0;
    tick();
    chk("ld_c1_strobes", {30'b0, mem_rd, mem_wr}, 32'd2);
    chk("ld_c1_hold_wdata", mem_data_in, 32'hDEAD_BEEF);
    dm_req = 1'b0;  // early drop must not cancel
    tick();
    chk("ld_c2_ack", {31'b0, dm_ack}, 32'd0);
    tick();
    chk("ld_c3_acks", {30'b0, if_ack, dm_ack}, 32'd1);
    chk("ld_c3_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk("ld_c3_if_rdata_hold", if_rdata, 32'hC200_2818);
    tick();
    chk("ld_c4_busy", {31'b0, busy}, 32'd0);

    // Contention: 4 data grants, then fetch, then data again
    exp_fetch = 6'b010000;
    got = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd12;
    if_req = 1'b1; if_addr = 32'd2048;
    for (int c = 0; c < 60 && got < 6; c++) begin
      tick();
      if (if_ack || dm_ack) begin
        chk($sformatf("contend_owner%0d", got), {30'b0, if_ack, dm_ack},
            exp_fetch[got] ? 32'd2 : 32'd1);
        chk($sformatf("contend_data%0d", got), if_ack ? if_rdata : dm_rdata,
            exp_fetch[got] ? 32'hC200_2818 : 32'hDEAD_BEEF);
        got++;
        if (got == 6) begin
          dm_req = 1'b0; if_req = 1'b0;
        end
      end
    end
    chk("contend_ack_count", got, 32'd6);
    tick();
    chk("contend_idle", {31'b0, busy}, 32'd0);

    // MEM_LAT=3 fetch on the second instance
    if_req3 = 1'b1; if_addr3 = 32'd2052;
    tick();
    chk("lat3_c1_rd", {30'b0, mem_rd3, mem_wr3}, 32'd2);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk($sformatf("lat3_c%0d_quiet", c), {30'b0, mem_rd3, if_ack3}, 32'd0);
    end
    tick();
    chk("lat3_c5_ack", {31'b0, if_ack3}, 32'd1);
    chk("lat3_c5_rdata", if_rdata3, 32'hC400_2814);
    if_req3 = 1'b0;
    tick();
    chk("lat3_c6_ack", {31'b0, if_ack3}, 32'd0);

    // Reset during WAIT, then a fresh fetch
    if_req = 1'b1; if_addr = 32'd2048;
    tick(); tick();
    rst = 1'b0; if_req = 1'b0;
    tick();
    chk("midrst_ack", {30'b0, if_ack, dm_ack}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_if_rdata", if_rdata, 32'd0);
    rst = 1'b1;
    tick();
    chk("midrst_no_late_ack", {31'b0, if_ack}, 32'd0);
    if_req = 1'b1; if_addr = 32'd2052;
    tick(); tick(); tick();
    chk("post_rst_ack", {31'b0, if_ack}, 32'd1);
    chk("post_rst_rdata", if_rdata, 32'hC400_2814);
    if_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port main memory between the instruction-fetch path and the load/store (data) path of the ARC datapath.
- Arbitrates the two requests, sequences the memory rd/wr strobes and waits out the memory's registered read latency.
- Returns read data with a one-cycle acknowledge pulse to the winning requester.
- Data accesses take priority; a starvation counter guarantees forward progress for fetch.

Parameters:
MEM_LAT, 1, cycles from mem_rd strobe edge until mem_data_out is valid (>=1)
STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before fetch is forced

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  reset; one clock; reset is synchronous and active-low
if_req  input  1  fetch read request, held until if_ack
if_addr  input  32  fetch word address
if_ack  output  1  one-cycle pulse, fetch complete, if_rdata valid this cycle
if_rdata  output  32  fetched word
dm_req  input  1  data request, held until dm_ack
dm_we  input  1  1=write, 0=read
dm_addr  input  32  data address
dm_wdata  input  32  store data
dm_ack  output  1  one-cycle pulse, data access complete
dm_rdata  output  32  load data, valid with dm_ack on reads
mem_address  output  32  to memory address
mem_data_in  output  32  to memory write data
mem_rd  output  1  memory read strobe
mem_wr  output  1  memory write strobe
mem_data_out  input  32  from memory, registered read data
busy  output  1  high in any state other than IDLE

Behaviour:
- All outputs registered. On rst=0 at a clock edge: state=IDLE, every output 0, starvation counter 0, latched winner cleared.
- States:
  - IDLE: sample requests and pick a winner. Latch addr/we/wdata and the owner, then go to ISSUE. With no request, stay in IDLE.
  - ISSUE: exactly one cycle. Drive mem_address, and mem_rd=1 (read) or mem_wr=1 plus mem_data_in (write). Read goes to WAIT with the latency counter loaded to MEM_LAT. Write goes to RESP.
  - WAIT: decrement the counter each cycle. On the cycle it reads 1, capture mem_data_out into the owner's rdata register and go to RESP.
  - RESP: pulse the owner's ack for one cycle, then go to IDLE.
- Latency from req high in IDLE to ack: write 2 cycles; read 2+MEM_LAT cycles.
- mem_rd and mem_wr are never high together, and are high only in ISSUE. mem_address and mem_data_in hold the last value outside ISSUE.
- Arbitration in IDLE:
  - Only dm_req: grant data. Only if_req: grant fetch.
  - Both: grant data unless starve_cnt==STARVE_MAX, in which case grant fetch.
- Starvation counter:
  - Increments on each data grant while if_req=1, saturating at STARVE_MAX.
  - Clears on a fetch grant, or in any IDLE cycle with if_req=0.
- Requester rules:
  - A requester must hold req and its fields stable until ack.
  - A req still high in the cycle after ack is a new request.
  - Deasserting req before ack does not cancel the transaction; it completes and acks anyway.
- The non-owner's ack stays 0. The non-owner's rdata holds its previous value.
- Reset mid-operation returns to IDLE on the next edge with no ack. A write already strobed in ISSUE has been committed by memory.
- No address decoding or alignment checks; addresses pass through unchanged.

Test Plan:
- Reset: hold rst=0 for 2 cycles with both reqs high -> all outputs 0, busy=0, no mem strobes.
- Single fetch: if_req=1, if_addr=2048, memory word 0xC2002818 -> mem_rd=1 for one cycle at cycle 1; if_ack=1 with if_rdata=0xC2002818 at cycle 3 (MEM_LAT=1).
- Store then load: dm write addr=12, data=0xDEADBEEF -> mem_wr pulse, dm_ack at cycle 2. Then dm read addr=12 -> dm_rdata=0xDEADBEEF with dm_ack.
- Contention: both reqs held continuously, dm reads -> data wins 4 consecutive grants, 5th grant goes to fetch (if_ack), counter clears, then data again.
- MEM_LAT=3: read addr=2052 -> ack at cycle 5 with rdata=0xC4002814. mem_rd high only in cycle 1.
- Reset mid-read: drop rst during WAIT -> no ack, state IDLE next cycle. A new if_req afterward completes normally.
